// File: rtl/spi_led_blinker_pkg.sv
// Shared encodings for the SPI-programmed LED blinker: frame opcodes, channel modes
// and the frame-assembly FSM state type.
package spi_led_blinker_pkg;

  localparam logic [1:0] OP_SET_HALF = 2'b00;
  localparam logic [1:0] OP_SET_MODE = 2'b01;
  localparam logic [1:0] OP_RESTART  = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: half-period toggle counter with OFF/ON/BLINK output selection and a
// synchronous restart that returns the channel to counter 0, led 0.
module blink_channel
  import spi_led_blinker_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] half,
  input  logic [1:0]       mode,
  input  logic             restart,
  output logic             led,
  output logic             led_en
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  always_comb begin
    cnt_d = '0;
    led_d = 1'b0;
    if (!restart && mode == MODE_BLINK) begin
      if (half == '0) begin
        led_d = led_q;  // zero half-period freezes the current level
      end else if (cnt_q == half - ONE) begin
        led_d = ~led_q;
      end else begin
        cnt_d = cnt_q + ONE;
        led_d = led_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led    = (mode == MODE_ON) | ((mode == MODE_BLINK) & led_q);
  assign led_en = (mode != MODE_OFF);

endmodule

// File: rtl/spi_led_blinker.sv
// Multi-channel LED blinker programmed by framed commands arriving as SPI-slave bytes:
// header [7:6] opcode / [5:0] channel, then CNT_W/8 data bytes MSB first.
module spi_led_blinker
  import spi_led_blinker_pkg::*;
#(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_HALF = 25_000_000,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_rx_done,
  input  logic [7:0]        spi_rx_data,
  output logic [CH_NUM-1:0] led,
  output logic [CH_NUM-1:0] led_en,
  output logic              clk_en,
  output logic              cmd_err
);

  localparam int unsigned      NB        = CNT_W / 8;
  localparam int unsigned      BCW       = $clog2(NB + 1);
  localparam int unsigned      TOW       = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(NB - 1);
  localparam logic [TOW-1:0]   TO_LIMIT  = TOW'(TIMEOUT);
  localparam logic [CNT_W-1:0] HALF_RST  = CNT_W'(DEF_HALF);

  state_e             state_q, state_d;
  logic [7:0]         hdr_q, hdr_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic [TOW-1:0]     idle_q, idle_d;
  logic [CNT_W-1:0]   half_q [CH_NUM];
  logic [CNT_W-1:0]   half_d [CH_NUM];
  logic [1:0]         mode_q [CH_NUM];
  logic [1:0]         mode_d [CH_NUM];
  logic [CH_NUM-1:0]  restart;

  logic [1:0] op;
  logic [5:0] ch;
  logic       ch_ok;
  logic       frame_err;

  assign op        = hdr_q[7:6];
  assign ch        = hdr_q[5:0];
  assign ch_ok     = 32'(ch) < CH_NUM;
  assign frame_err = (op == OP_RSVD) || (op != OP_RESTART && !ch_ok) ||
                     (op == OP_SET_MODE && data_q[1:0] == 2'b11);
  assign clk_en    = 1'b1;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    idle_d  = idle_q;
    half_d  = half_q;
    mode_d  = mode_q;
    restart = '0;
    cmd_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (spi_rx_done) begin
          hdr_d   = spi_rx_data;
          bcnt_d  = '0;
          idle_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (spi_rx_done) begin
          data_d = (data_q << 8) | CNT_W'(spi_rx_data);
          bcnt_d = bcnt_q + BCW'(1);
          idle_d = '0;
          if (bcnt_q == LAST_BYTE) begin
            state_d = ST_COMMIT;
          end
        end else if (idle_q == TO_LIMIT) begin
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + TOW'(1);
        end
      end
      ST_COMMIT: begin
        if (frame_err) begin
          cmd_err = 1'b1;
        end else begin
          for (int i = 0; i < CH_NUM; i++) begin
            if (op == OP_RESTART) begin
              restart[i] = 1'b1;
            end else if (ch == 6'(i)) begin
              restart[i] = 1'b1;
              if (op == OP_SET_HALF) begin
                half_d[i] = data_q;
              end else begin
                mode_d[i] = data_q[1:0];
              end
            end
          end
        end
        // A byte landing in the commit cycle is the next frame's header.
        if (spi_rx_done) begin
          hdr_d   = spi_rx_data;
          bcnt_d  = '0;
          idle_d  = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      idle_q  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        half_q[i] <= HALF_RST;
        mode_q[i] <= MODE_BLINK;
      end
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      idle_q  <= idle_d;
      half_q  <= half_d;
      mode_q  <= mode_d;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    blink_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .half   (half_q[g]),
      .mode   (mode_q[g]),
      .restart(restart[g]),
      .led    (led[g]),
      .led_en (led_en[g])
    );
  end

endmodule

// File: tb/tb_spi_led_blinker.sv
// Directed bench for spi_led_blinker: a byte-stream frame model predicts every channel's
// led/led_en and the cmd_err pulse each cycle, plus hand-computed spot values.
module tb_spi_led_blinker;

  localparam int unsigned CH_NUM   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 4;
  localparam int unsigned TIMEOUT  = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_rx_done = 1'b0;
  logic [7:0]        spi_rx_data = 8'h00;
  logic [CH_NUM-1:0] led;
  logic [CH_NUM-1:0] led_en;
  logic              clk_en;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  spi_led_blinker #(
    .CH_NUM  (CH_NUM),
    .CNT_W   (CNT_W),
    .DEF_HALF(DEF_HALF),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_rx_done(spi_rx_done),
    .spi_rx_data(spi_rx_data),
    .led        (led),
    .led_en     (led_en),
    .clk_en     (clk_en),
    .cmd_err    (cmd_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel's led is a pure function of mode, half-period and the number of
  // clock edges since that channel last restarted.
  int         t_m    [CH_NUM];
  int         half_m [CH_NUM];
  int         mode_m [CH_NUM];
  logic [7:0] fq [$];
  logic [7:0] pf [3];
  int         idle_m;
  int         op_m, ch_m, val_m;
  bit         pend, exp_err;

  function automatic bit frame_bad(input logic [7:0] h, input logic [15:0] v);
    int op = int'(h[7:6]);
    int ch = int'(h[5:0]);
    if (op == 3) return 1'b1;
    if (op == 2) return 1'b0;
    if (ch >= CH_NUM) return 1'b1;
    return (op == 1) && (v[1:0] == 2'b11);
  endfunction

  function automatic logic exp_led(input int m, input int h, input int t);
    if (m == 1) return 1'b1;
    if (m != 2 || h == 0) return 1'b0;
    return ((t / h) % 2) == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        t_m[i]    = 0;
        half_m[i] = DEF_HALF;
        mode_m[i] = 2;
      end
      fq.delete();
      idle_m  = 0;
      pend    = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      for (int i = 0; i < CH_NUM; i++) t_m[i]++;
      if (pend) begin
        pend  = 1'b0;
        op_m  = int'(pf[0][7:6]);
        ch_m  = int'(pf[0][5:0]);
        val_m = int'({pf[1], pf[2]});
        if (!frame_bad(pf[0], {pf[1], pf[2]})) begin
          if (op_m == 2) begin
            for (int i = 0; i < CH_NUM; i++) t_m[i] = 0;
          end else begin
            t_m[ch_m] = 0;
            if (op_m == 0) half_m[ch_m] = val_m;
            else mode_m[ch_m] = val_m % 4;
          end
        end
      end
      if (spi_rx_done) begin
        fq.push_back(spi_rx_data);
        idle_m = 0;
        if (fq.size() == 3) begin
          pf[0] = fq[0];
          pf[1] = fq[1];
          pf[2] = fq[2];
          fq.delete();
          pend    = 1'b1;
          exp_err = frame_bad(pf[0], {pf[1], pf[2]});
        end
      end else if (fq.size() != 0) begin
        idle_m++;
        if (idle_m > TIMEOUT) begin
          fq.delete();
          idle_m = 0;
        end
      end
    end
  end

  logic [CH_NUM-1:0] el, ee;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        el[i] = exp_led(mode_m[i], half_m[i], t_m[i]);
        ee[i] = (mode_m[i] != 0);
      end
      chk("led", 32'(led), 32'(el));
      chk("led_en", 32'(led_en), 32'(ee));
      chk("cmd_err", 32'(cmd_err), 32'(exp_err));
      chk("clk_en", 32'(clk_en), 32'd1);
      if (cmd_err) err_pulses++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bytes go out on consecutive cycles; back-to-back calls put the next header in COMMIT.
  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    spi_rx_done = 1'b1;
    spi_rx_data = b0;
    @(negedge clk);
    spi_rx_data = b1;
    @(negedge clk);
    spi_rx_data = b2;
    @(negedge clk);
    spi_rx_done = 1'b0;
  endtask

  int p0;

  initial begin
    idle(3);
    rst_n = 1'b1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_led_en", 32'(led_en), 32'hF);
    chk("rst_cmd_err", 32'(cmd_err), 32'h0);
    idle(4);
    chk("def_blink_hi", 32'(led), 32'hF);
    idle(4);
    chk("def_blink_lo", 32'(led), 32'h0);
    idle(12);

    // SET_HALF ch1 = 2
    send(8'h01, 8'h00, 8'h02);
    chk("set_half_no_err", 32'(cmd_err), 32'h0);
    idle(1);
    chk("ch1_after_commit", 32'(led[1]), 32'h0);
    idle(2);
    chk("ch1_first_toggle", 32'(led[1]), 32'h1);
    idle(10);

    // SET_MODE ch2 ON then OFF
    send(8'h42, 8'h00, 8'h01);
    idle(1);
    chk("ch2_on_led", 32'(led[2]), 32'h1);
    chk("ch2_on_en", 32'(led_en), 32'hF);
    idle(5);
    send(8'h42, 8'h00, 8'h00);
    idle(1);
    chk("ch2_off_led", 32'(led[2]), 32'h0);
    chk("ch2_off_en", 32'(led_en), 32'hB);
    idle(5);

    // Rejected frames: bad channel, opcode 11, mode 3
    p0 = err_pulses;
    send(8'h05, 8'h00, 8'h03);
    chk("bad_ch_err", 32'(cmd_err), 32'h1);
    idle(3);
    send(8'hC0, 8'h00, 8'h00);
    chk("rsvd_op_err", 32'(cmd_err), 32'h1);
    idle(3);
    send(8'h41, 8'h00, 8'h03);
    chk("mode3_err", 32'(cmd_err), 32'h1);
    idle(3);
    chk("err_pulse_count", 32'(err_pulses - p0), 32'd3);
    chk("err_no_change_en", 32'(led_en), 32'hB);

    // Partial frame abandoned by timeout, then a full SET_HALF ch0 = 6
    spi_rx_done = 1'b1;
    spi_rx_data = 8'h00;
    @(negedge clk);
    spi_rx_data = 8'h00;
    @(negedge clk);
    spi_rx_done = 1'b0;
    idle(60);
    send(8'h00, 8'h00, 8'h06);
    chk("timeout_no_err", 32'(cmd_err), 32'h0);
    idle(6);
    chk("ch0_half6_lo", 32'(led[0]), 32'h0);
    idle(1);
    chk("ch0_half6_hi", 32'(led[0]), 32'h1);
    idle(5);

    // Drift channels apart, then RESTART
    send(8'h01, 8'h00, 8'h04);
    send(8'h42, 8'h00, 8'h02);
    idle(7);
    send(8'h80, 8'h00, 8'h00);
    idle(1);
    chk("restart_all_zero", 32'(led), 32'h0);
    idle(4);
    chk("restart_lockstep", 32'(led), 32'hE);
    idle(6);

    // Back-to-back frames: ch2 half = 3, ch3 ON
    send(8'h02, 8'h00, 8'h03);
    send(8'h43, 8'h00, 8'h01);
    idle(1);
    chk("b2b_both_applied", 32'(led[3:2]), 32'h3);
    idle(6);

    // Half-period 0 holds the level
    send(8'h00, 8'h00, 8'h00);
    idle(20);
    chk("half0_holds", 32'(led[0]), 32'h0);

    // Reset in the middle of a frame
    spi_rx_done = 1'b1;
    spi_rx_data = 8'h41;
    @(negedge clk);
    spi_rx_data = 8'h00;
    @(negedge clk);
    spi_rx_done = 1'b0;
    #2 rst_n = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    chk("midreset_led", 32'(led), 32'h0);
    chk("midreset_en", 32'(led_en), 32'hF);
    @(negedge clk);
    send(8'h03, 8'h00, 8'h02);
    idle(1);
    chk("post_reset_frame_en", 32'(led_en), 32'hF);
    idle(2);
    chk("post_reset_ch3", 32'(led[3]), 32'h1);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_led_blinker.md
Name: spi_led_blinker

Overview:
- Multi-channel LED blinker; each channel's half-period and mode are programmable over the SPI-slave byte stream.
- Sits between the SPI slave receiver (rx byte + done strobe) and the board LED pins; replaces the single-channel blinker.
- Adds framed commands, per-channel on/off/blink modes, synchronous restart, error flagging and a mid-frame timeout.

Parameters:
- CH_NUM, 4, number of LED channels (1..64).
- CNT_W, 32, counter/half-period width in bits; multiple of 8, 8..32.
- DEF_HALF, 25_000_000, reset half-period in clk cycles for every channel (0.5 s at 50 MHz).
- TIMEOUT, 1_000_000, idle clk cycles mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- spi_rx_done  in  1  one-cycle strobe: spi_rx_data is valid.
- spi_rx_data  in  8  received SPI byte.
- led  out  CH_NUM  LED pin levels.
- led_en  out  CH_NUM  per-channel pin enable; 1 when that channel's mode is not OFF.
- clk_en  out  1  clock input enable; constant 1.
- cmd_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Frame layout:
  - Header byte: [7:6] opcode, [5:0] channel index.
  - Followed by NB = CNT_W/8 data bytes, MSB first.
  - Every opcode uses the full 1+NB byte frame.
- Opcodes:
  - 00 SET_HALF: channel half-period = data.
  - 01 SET_MODE: data[1:0] selects mode. 0 OFF, 1 ON, 2 BLINK, 3 reserved → error.
  - 10 RESTART: every channel's counter is cleared and led is set to 0 on commit; channel field is ignored.
  - 11 reserved → error.
- FSM states:
  - IDLE: rx_done latches the header and moves to DATA with byte count 0.
  - DATA: rx_done shifts the byte into the assembly register and increments the count. The NB-th byte moves to COMMIT.
  - COMMIT: lasts one cycle and applies the frame or raises cmd_err, then returns to IDLE. An rx_done arriving in COMMIT is accepted as the next frame's header, exactly as in IDLE.
- Timeout: the idle counter runs in DATA and resets on every rx_done. When it reaches TIMEOUT, go to IDLE; no update, no cmd_err.
- Error cases (cmd_err=1 during the COMMIT cycle, no state change):
  - channel index >= CH_NUM for SET_HALF or SET_MODE;
  - opcode 11;
  - mode 3.
- Commit latency: registers update at the COMMIT clock edge. The channel counter clears to 0 on the same edge, and led restarts at 0 in BLINK.
- Per-channel channel operation:
  - BLINK: counter increments each cycle. When counter == half-1, counter→0 and led toggles, so period = 2*half cycles.
  - BLINK with half==0: counter holds 0 and led holds its current level.
  - ON: led=1. OFF: led=0 and led_en=0. In both, counter holds 0.
  - Mode change into BLINK starts from counter 0, led 0.
- Width rule: counter is CNT_W bits; half = 2^CNT_W-1 is valid. The counter never exceeds half-1, so no overflow.
- Reset values:
  - led=0, led_en=all 1, cmd_err=0, clk_en=1;
  - mode=BLINK, half=DEF_HALF, counters=0, FSM=IDLE.
- Reset asserted mid-frame discards the partial frame.

Decomposition:
- Package spi_led_blinker_pkg holds:
  - opcode localparams (OP_SET_HALF, OP_SET_MODE, OP_RESTART, OP_RSVD);
  - mode encodings (MODE_OFF, MODE_ON, MODE_BLINK);
  - the FSM state enum (ST_IDLE, ST_DATA, ST_COMMIT).
- Sub-module blink_channel: one instance per channel via a generate loop.
  - Inputs: clk, rst_n, half, mode, restart pulse.
  - Outputs: led bit, led_en bit.
- Top level contains the frame FSM, assembly register, timeout counter and per-channel register file.

Test Plan (bench parameters CNT_W=16, CH_NUM=4, DEF_HALF=4, TIMEOUT=50):
- Reset release, no SPI traffic → all led toggle every 4 cycles (period 8), in phase; cmd_err stays 0.
- Frame 0x01,0x00,0x02 (SET_HALF ch1 = 2) → ch1 toggles every 2 cycles starting 2 cycles after commit; other channels unaffected.
- Frame 0x42,0x00,0x01 (SET_MODE ch2 ON) → led[2]=1 steady, led_en[2]=1. Then 0x42,0x00,0x00 (OFF) → led[2]=0, led_en[2]=0.
- Frame 0x05,0x00,0x03 (channel 5 out of range), then 0xC0,0,0 (opcode 11) → cmd_err pulses once per frame; no register changes.
- Header 0x00, one data byte, then 60 idle cycles, then frame 0x00,0x00,0x06 → partial frame dropped; ch0 half=6, no cmd_err.
- Frame 0x80,0,0 (RESTART) after channels drift out of phase → all counters 0 and led 0 on commit; channels with equal half toggle in lockstep afterwards.
- Back-to-back frames, with the next header's rx_done in the COMMIT cycle → both frames applied.
- Reset asserted mid-frame → FSM in IDLE, registers at reset values.
